// File: rtl/tl_req_arbiter.sv
// tl_req_arbiter: round-robin sharing of one TileLink-UL master between two requesters.
// Define ARB_TIMEOUT_EN to build a watchdog that aborts stalled transactions with err=1.
module tl_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_wr,
    input  logic        req0_rd,
    input  logic [3:0]  req0_byte,
    input  logic [3:0]  req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic        req0_err,
    input  logic        req1_wr,
    input  logic        req1_rd,
    input  logic [3:0]  req1_byte,
    input  logic [3:0]  req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic        req1_err,
    output logic        m_cpu_wr,
    output logic        m_cpu_rd,
    output logic [3:0]  m_cpu_byte,
    output logic [3:0]  m_cpu_addr,
    output logic [31:0] m_cpu_wdata,
    input  logic        m_cpu_rdata_v,
    input  logic [31:0] m_cpu_rdata,
    input  logic        m_trans_over,
    output logic        owner,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, WAIT_START, WAIT_DONE, DONE} state_t;

    state_t      state_q, state_d;
    logic        rr_ptr_q, rr_ptr_d;
    logic        owner_q, owner_d;
    logic        busy_q, busy_d;
    logic        op_rd_q, op_rd_d;
    logic        m_wr_q, m_wr_d;
    logic        m_rd_q, m_rd_d;
    logic [3:0]  m_byte_q, m_byte_d;
    logic [3:0]  m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done0_q, done0_d, done1_q, done1_d;
    logic        err0_q, err0_d, err1_q, err1_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic        pend0, pend1, winner;
    logic [31:0] rdata_fwd;
    logic        complete, abort, timeout;

    // Marker block: elaborates only for a watchdog limit the counter cannot reach.
    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_timeout_exceeds_cnt_w
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == WAIT_START || state_q == WAIT_DONE) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (state_q == WAIT_START || state_q == WAIT_DONE) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    assign pend0  = req0_wr | req0_rd;
    assign pend1  = req1_wr | req1_rd;
    assign winner = (pend0 && pend1) ? ~rr_ptr_q : pend1;
    // A beat landing on the completing edge must still reach the requester.
    assign rdata_fwd = (m_cpu_rdata_v && op_rd_q) ? m_cpu_rdata : rdata_q;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        op_rd_d   = op_rd_q;
        m_wr_d    = 1'b0;
        m_rd_d    = 1'b0;
        m_byte_d  = m_byte_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        rdata_d   = rdata_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err0_d    = err0_q;
        err1_d    = err1_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        complete  = 1'b0;
        abort     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend0 || pend1) begin
                    state_d  = WAIT_START;
                    owner_d  = winner;
                    rr_ptr_d = winner;
                    if (winner) begin
                        m_wr_d    = req1_wr;
                        m_rd_d    = req1_rd & ~req1_wr;
                        m_byte_d  = req1_byte;
                        m_addr_d  = req1_addr;
                        m_wdata_d = req1_wdata;
                    end else begin
                        m_wr_d    = req0_wr;
                        m_rd_d    = req0_rd & ~req0_wr;
                        m_byte_d  = req0_byte;
                        m_addr_d  = req0_addr;
                        m_wdata_d = req0_wdata;
                    end
                    op_rd_d = m_rd_d;
                end
            end
            WAIT_START: begin
                if (!m_trans_over) begin
                    state_d = WAIT_DONE;
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (m_cpu_rdata_v && op_rd_q) begin
                    rdata_d = m_cpu_rdata;
                end
                if (m_trans_over) begin
                    complete = 1'b1;
                end else if (timeout) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                m_byte_d  = '0;
                m_addr_d  = '0;
                m_wdata_d = '0;
            end
        endcase

        if (complete || abort) begin
            state_d = DONE;
            if (owner_q) begin
                done1_d = 1'b1;
                err1_d  = abort;
                if (complete && op_rd_q) rdata1_d = rdata_fwd;
            end else begin
                done0_d = 1'b1;
                err0_d  = abort;
                if (complete && op_rd_q) rdata0_d = rdata_fwd;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= 1'b0;
            owner_q   <= 1'b0;
            busy_q    <= 1'b0;
            op_rd_q   <= 1'b0;
            m_wr_q    <= 1'b0;
            m_rd_q    <= 1'b0;
            m_byte_q  <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            rdata_q   <= '0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
            op_rd_q   <= op_rd_d;
            m_wr_q    <= m_wr_d;
            m_rd_q    <= m_rd_d;
            m_byte_q  <= m_byte_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            rdata_q   <= rdata_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign req0_done   = done0_q;
    assign req0_rdata  = rdata0_q;
    assign req0_err    = err0_q;
    assign req1_done   = done1_q;
    assign req1_rdata  = rdata1_q;
    assign req1_err    = err1_q;
    assign m_cpu_wr    = m_wr_q;
    assign m_cpu_rd    = m_rd_q;
    assign m_cpu_byte  = m_byte_q;
    assign m_cpu_addr  = m_addr_q;
    assign m_cpu_wdata = m_wdata_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_tl_req_arbiter.sv
// Randomized scoreboard bench for tl_req_arbiter: requester and master models drive the DUT,
// a monitor predicts grants, strobes and completions from the arbitration rules.
`timescale 1ns/1ps
module tb_tl_req_arbiter;
    logic        clk, rst;
    logic        req0_wr, req0_rd, req1_wr, req1_rd;
    logic [3:0]  req0_byte, req0_addr, req1_byte, req1_addr;
    logic [31:0] req0_wdata, req1_wdata;
    logic        req0_done, req0_err, req1_done, req1_err;
    logic [31:0] req0_rdata, req1_rdata;
    logic        m_cpu_wr, m_cpu_rd, m_cpu_rdata_v, m_trans_over, owner, busy;
    logic [3:0]  m_cpu_byte, m_cpu_addr;
    logic [31:0] m_cpu_wdata, m_cpu_rdata;

    tl_req_arbiter #(.TIMEOUT_CYCLES(10), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_wr(req0_wr), .req0_rd(req0_rd), .req0_byte(req0_byte), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
        .req1_wr(req1_wr), .req1_rd(req1_rd), .req1_byte(req1_byte), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
        .m_cpu_wr(m_cpu_wr), .m_cpu_rd(m_cpu_rd), .m_cpu_byte(m_cpu_byte), .m_cpu_addr(m_cpu_addr),
        .m_cpu_wdata(m_cpu_wdata), .m_cpu_rdata_v(m_cpu_rdata_v), .m_cpu_rdata(m_cpu_rdata),
        .m_trans_over(m_trans_over), .owner(owner), .busy(busy)
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [3:0]  byte_m;
        logic [3:0]  addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct {
        logic who;
        logic rd;
        logic err;
    } flight_t;

    txn_t        q0[$], q1[$];
    flight_t     inflight[$];
    logic        grant_log[$];
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  pend_snap;
    logic        mst_en, mst_fixed_en, tmo_mode;
    logic [31:0] mst_fixed_data, mst_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_watchdog actual=stuck required=finish");
        $fatal(1, "bench watchdog expired");
    end

    always @(posedge clk) pend_snap <= {req1_wr | req1_rd, req0_wr | req0_rd};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=missing required=present", name);
    endtask

    function automatic logic [11:0] out_flags();
        return {req0_done, req0_err, |req0_rdata, req1_done, req1_err, |req1_rdata,
                m_cpu_wr, m_cpu_rd, |{m_cpu_byte, m_cpu_addr, m_cpu_wdata}, owner, busy, 1'b0};
    endfunction

    // Monitor: predicts each grant from the requests visible at the deciding edge.
    initial begin
        logic        rr_m, prev_strobe, strobe, w;
        logic [31:0] mdl_rdata [2];
        txn_t        t;
        flight_t     f;
        rr_m = 1'b0; prev_strobe = 1'b0; mdl_rdata[0] = '0; mdl_rdata[1] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("reset_outputs", 64'(out_flags()), 64'd0);
                rr_m = 1'b0; prev_strobe = 1'b0;
                mdl_rdata[0] = '0; mdl_rdata[1] = '0;
                inflight.delete();
            end else begin
                strobe = m_cpu_wr | m_cpu_rd;
                if (inflight.size() > 0) chk("busy_in_txn", 64'(busy), 64'd1);
                if (strobe) begin
                    chk("strobe_width", 64'(prev_strobe), 64'd0);
                    if (pend_snap == 2'b00) begin
                        fail_now("spurious_strobe");
                    end else begin
                        w = (pend_snap == 2'b11) ? ~rr_m : pend_snap[1];
                        rr_m = w;
                        if ((w && q1.size() == 0) || (!w && q0.size() == 0)) begin
                            fail_now("expected_txn");
                        end else begin
                            t = w ? q1.pop_front() : q0.pop_front();
                            grant_log.push_back(owner);
                            chk("grant_owner", 64'(owner), 64'(w));
                            chk("strobe_wr", 64'(m_cpu_wr), 64'(t.wr));
                            chk("strobe_rd", 64'(m_cpu_rd), 64'(t.rd & ~t.wr));
                            chk("strobe_fields", 64'({m_cpu_byte, m_cpu_addr, m_cpu_wdata}),
                                64'({t.byte_m, t.addr, t.wdata}));
                            inflight.push_back('{who: w, rd: t.rd & ~t.wr, err: tmo_mode});
                        end
                    end
                end
                prev_strobe = strobe;
                if (req0_done || req1_done) begin
                    if (inflight.size() == 0) begin
                        chk("unexpected_done", 64'({req1_done, req0_done}), 64'd0);
                    end else begin
                        f = inflight.pop_front();
                        chk("done_select", 64'({req1_done, req0_done}), f.who ? 64'd2 : 64'd1);
                        chk("done_err", 64'(f.who ? req1_err : req0_err), 64'(f.err));
                        if (f.rd && !f.err) mdl_rdata[f.who] = mst_data;
                        chk("rdata_owner", 64'(f.who ? req1_rdata : req0_rdata), 64'(mdl_rdata[f.who]));
                        chk("rdata_other", 64'(f.who ? req0_rdata : req1_rdata), 64'(mdl_rdata[!f.who]));
                    end
                end
            end
        end
    end

    // Master model: answers each strobe with trans_over 1->0->1 and some data beats.
    initial begin
        logic is_rd;
        int   nb;
        m_trans_over = 1'b1; m_cpu_rdata_v = 1'b0; m_cpu_rdata = '0; mst_data = '0;
        forever begin
            @(negedge clk);
            if (mst_en && !rst && (m_cpu_wr || m_cpu_rd)) begin
                is_rd = m_cpu_rd;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                m_trans_over = 1'b0;
                nb = mst_fixed_en ? 1 : int'($urandom_range(1, 3));
                for (int i = 0; i < nb; i++) begin
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                    if (is_rd || $urandom_range(0, 1) == 1) begin
                        m_cpu_rdata   = mst_fixed_en ? mst_fixed_data : $urandom;
                        m_cpu_rdata_v = 1'b1;
                        if (is_rd) mst_data = m_cpu_rdata;
                        @(negedge clk);
                        m_cpu_rdata_v = 1'b0;
                    end
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                m_trans_over = 1'b1;
            end
        end
    end

    task automatic drive_req(input int id, input logic wr, input logic rd, input logic [3:0] bm,
                             input logic [3:0] ad, input logic [31:0] wd);
        if (id == 0) begin
            req0_wr = wr; req0_rd = rd; req0_byte = bm; req0_addr = ad; req0_wdata = wd;
        end else begin
            req1_wr = wr; req1_rd = rd; req1_byte = bm; req1_addr = ad; req1_wdata = wd;
        end
    endtask

    task automatic do_req(input int id, input logic wr, input logic rd, input logic [3:0] bm,
                          input logic [3:0] ad, input logic [31:0] wd);
        txn_t t;
        int   n;
        t.wr = wr; t.rd = rd; t.byte_m = bm; t.addr = ad; t.wdata = wd;
        if (id == 0) q0.push_back(t); else q1.push_back(t);
        drive_req(id, wr, rd, bm, ad, wd);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(id == 0 ? req0_done : req1_done) && n < 300);
        if (n >= 300) fail_now($sformatf("req%0d_done_wait", id));
        drive_req(id, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        @(negedge clk);
    endtask

    task automatic req_loop(input int id, input int count);
        int op;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            op = int'($urandom_range(0, 2));
            do_req(id, op != 1, op != 0, 4'($urandom), 4'($urandom), $urandom);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; mst_en = 1'b1; mst_fixed_en = 1'b0; tmo_mode = 1'b0; mst_fixed_data = '0;
        drive_req(0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        mst_fixed_en = 1'b1;
        mst_fixed_data = 32'h12345678;
        do_req(0, 1'b1, 1'b0, 4'hF, 4'h3, 32'hDEADBEEF);
        do_req(1, 1'b0, 1'b1, 4'h0, 4'h5, 32'h0);
        do_req(0, 1'b1, 1'b1, 4'h3, 4'hA, 32'h0BADF00D);
        mst_fixed_en = 1'b0;

        grant_log.delete();
        fork
            begin
                do_req(0, 1'b0, 1'b1, 4'h1, 4'h2, 32'h0);
                do_req(0, 1'b1, 1'b0, 4'h2, 4'h4, 32'hA5A5A5A5);
            end
            begin
                do_req(1, 1'b1, 1'b0, 4'h4, 4'h6, 32'h5A5A5A5A);
                do_req(1, 1'b0, 1'b1, 4'h8, 4'h8, 32'h0);
            end
        join
        chk("grant_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk($sformatf("grant_order_%0d", i), 64'(grant_log[i]), (i % 2 == 0) ? 64'd1 : 64'd0);

        fork
            req_loop(0, 25);
            req_loop(1, 25);
        join

        mst_en = 1'b0;
        @(negedge clk);
        q0.push_back('{wr: 1'b0, rd: 1'b1, byte_m: 4'h1, addr: 4'h7, wdata: 32'h0});
        drive_req(0, 1'b0, 1'b1, 4'h1, 4'h7, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_cpu_rd && n < 20);
        if (n >= 20) fail_now("reset_test_strobe");
        m_trans_over = 1'b0;
        repeat (2) @(negedge clk);
        m_cpu_rdata = 32'hCAFEF00D;
        m_cpu_rdata_v = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", 64'(out_flags()), 64'd0);
        drive_req(0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        m_cpu_rdata_v = 1'b0;
        m_trans_over = 1'b1;
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mst_en = 1'b1;
        do_req(0, 1'b1, 1'b0, 4'hC, 4'h9, 32'h600DCAFE);
        do_req(1, 1'b0, 1'b1, 4'h3, 4'h1, 32'h0);

`ifdef ARB_TIMEOUT_EN
        mst_en = 1'b0;
        tmo_mode = 1'b1;
        @(negedge clk);
        q0.push_back('{wr: 1'b0, rd: 1'b1, byte_m: 4'hF, addr: 4'h2, wdata: 32'h0});
        drive_req(0, 1'b0, 1'b1, 4'hF, 4'h2, 32'h0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_cpu_rd && n < 20);
        if (n >= 20) fail_now("timeout_test_strobe");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req0_done && n < 40);
        chk("timeout_latency", 64'(n), 64'd11);
        drive_req(0, 1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
        @(negedge clk);
        tmo_mode = 1'b0;
        mst_en = 1'b1;
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 64'(q0.size() + q1.size() + inflight.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
